// File: rtl/fifo_pkt_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry buffer and frames it into PKT_LEN-word packets.
// Optional feature: define FIFO_PKT_READER_CHECKSUM_EN to append a checksum beat to every packet.
module fifo_pkt_reader #(
   parameter int WIDTH   = 16,
   parameter int PKT_LEN = 8
) (
   input  logic             clk,
   input  logic             reset,
   output logic             fifo_deq,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_deq_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic [15:0]      pkt_cnt
);

   localparam int WCW = $clog2(PKT_LEN);
   localparam logic [WCW-1:0] LAST_IDX = WCW'(PKT_LEN - 1);

   logic [1:0]       occ;
   logic             inflight;
   logic [WIDTH-1:0] buf0;
   logic [WIDTH-1:0] buf1;
   logic [WCW-1:0]   wcnt;
   logic             pop_out;
   logic             data_phase;
   logic             last_word;

`ifdef FIFO_PKT_READER_CHECKSUM_EN
   typedef enum logic {DATA, CSUM} state_t;
   state_t           state;
   logic [WIDTH-1:0] acc;
`endif

   // Pop credit counts words already buffered plus the one still coming out of the FIFO.
   always_comb begin
      last_word = (wcnt == LAST_IDX);
`ifdef FIFO_PKT_READER_CHECKSUM_EN
      data_phase = (state == DATA);
      out_valid  = data_phase ? (occ != 2'd0) : 1'b1;
      out_data   = data_phase ? buf0 : acc;
      out_last   = !data_phase;
`else
      data_phase = 1'b1;
      out_valid  = (occ != 2'd0);
      out_data   = buf0;
      out_last   = out_valid & last_word;
`endif
      pop_out  = out_valid & out_ready & data_phase;
      fifo_deq = !reset & !fifo_empty &
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop_out}));
   end

   // buf0 is always the head; a pop shifts buf1 forward while an arriving word fills the next free slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
         buf0     <= '0;
         buf1     <= '0;
         wcnt     <= '0;
         pkt_cnt  <= 16'd0;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
         state    <= DATA;
         acc      <= '0;
`endif
      end else begin
         inflight <= fifo_deq;
         occ      <= occ + {1'b0, inflight} - {1'b0, pop_out};

         if (pop_out) begin
            if (occ == 2'd2) begin
               buf0 <= buf1;
               if (inflight)
                  buf1 <= fifo_deq_data;
            end else if (inflight) begin
               buf0 <= fifo_deq_data;
            end
         end else if (inflight) begin
            if (occ == 2'd0)
               buf0 <= fifo_deq_data;
            else
               buf1 <= fifo_deq_data;
         end

`ifdef FIFO_PKT_READER_CHECKSUM_EN
         if (pop_out) begin
            acc <= acc + buf0;
            if (last_word)
               state <= CSUM;
            else
               wcnt <= wcnt + 1'b1;
         end
         if (state == CSUM && out_ready) begin
            state   <= DATA;
            acc     <= '0;
            wcnt    <= '0;
            pkt_cnt <= pkt_cnt + 16'd1;
         end
`else
         if (pop_out) begin
            if (last_word) begin
               wcnt    <= '0;
               pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Randomised self-checking bench for fifo_pkt_reader with a queue-based FIFO and stream model.
// Honours FIFO_PKT_READER_CHECKSUM_EN so it can be built alongside either RTL configuration.
module tb_fifo_pkt_reader;

   localparam int WIDTH   = 16;
   localparam int PKT_LEN = 8;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fifo_deq;
   logic        fifo_empty = 1'b1;
   logic [15:0] fifo_deq_data = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic [15:0] pkt_cnt;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   logic [15:0] fq[$];
   logic [15:0] exp_q[$];
   int          beat_idx = 0;
   logic [15:0] acc = 16'h0;
   logic [15:0] pkt_model = 16'h0;
   logic        last_deq = 1'b0;
   logic        last_d = 1'b0;
   int          first_deq = -1;
   int          first_valid = -1;
   int          deq_count = 0;

   logic [15:0] hs_data[$];
   logic        hs_last[$];
   logic        hs_csum[$];
   int          hs_cyc[$];

   fifo_pkt_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_deq      (fifo_deq),
      .fifo_empty    (fifo_empty),
      .fifo_deq_data (fifo_deq_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .pkt_cnt       (pkt_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare against the model, then let the FIFO react.
   task automatic apply_stimulus(input logic rst, input logic rdy, input logic gate);
      logic        d;
      logic        csum;
      logic        exp_valid;
      logic        data_hs;
      logic        exp_deq;
      logic        exp_last;
      logic [15:0] exp_data;
      logic [15:0] w;
      int          captured;
      reset      = rst;
      out_ready  = rdy;
      fifo_empty = (fq.size() == 0) || gate;
      #1;
      d = fifo_deq;
      if (rst) begin
         check_output("reset_fifo_deq", {31'b0, fifo_deq}, 32'h0);
         check_output("reset_out_valid", {31'b0, out_valid}, 32'h0);
         check_output("reset_out_last", {31'b0, out_last}, 32'h0);
         check_output("reset_out_data", {16'b0, out_data}, 32'h0);
         check_output("reset_pkt_cnt", {16'b0, pkt_cnt}, 32'h0);
         exp_q.delete();
         beat_idx  = 0;
         acc       = 16'h0;
         pkt_model = 16'h0;
      end else begin
         csum      = CSUM_ON && (beat_idx == PKT_LEN);
         captured  = exp_q.size() - int'(last_deq);
         exp_valid = csum || (captured > 0);
         data_hs   = exp_valid && rdy && !csum;
         exp_deq   = !fifo_empty && ((exp_q.size() - int'(data_hs)) < 2);
         exp_data  = csum ? acc : ((exp_q.size() > 0) ? exp_q[0] : 16'h0);
         exp_last  = CSUM_ON ? csum : (exp_valid && beat_idx == PKT_LEN - 1);
         check_output("fifo_deq", {31'b0, fifo_deq}, {31'b0, exp_deq});
         check_output("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
         check_output("pkt_cnt", {16'b0, pkt_cnt}, {16'b0, pkt_model});
         if (exp_valid) begin
            check_output("out_data", {16'b0, out_data}, {16'b0, exp_data});
            check_output("out_last", {31'b0, out_last}, {31'b0, exp_last});
         end
         if (d && first_deq < 0)
            first_deq = cycle;
         if (out_valid && first_valid < 0)
            first_valid = cycle;
         if (d)
            deq_count++;
         if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_last.push_back(out_last);
            hs_csum.push_back(csum);
            hs_cyc.push_back(cycle);
         end
         if (exp_valid && rdy) begin
            if (csum) begin
               beat_idx = 0;
               acc      = 16'h0;
               pkt_model++;
            end else begin
               w   = exp_q.pop_front();
               acc = acc + w;
               if (beat_idx == PKT_LEN - 1) begin
                  if (CSUM_ON) begin
                     beat_idx = PKT_LEN;
                  end else begin
                     beat_idx = 0;
                     pkt_model++;
                  end
               end else begin
                  beat_idx++;
               end
            end
         end
      end
      last_d = d;
      @(posedge clk);
      cycle++;
      @(negedge clk);
      if (d) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_when_empty: got fifo_deq=1 expected 0 (cycle %0d)", cycle);
         end else begin
            w = fq.pop_front();
            fifo_deq_data = w;
            if (!rst)
               exp_q.push_back(w);
         end
      end
      last_deq = rst ? 1'b0 : d;
   endtask

   task automatic do_reset(input int n);
      repeat (n) apply_stimulus(1'b1, 1'b0, 1'b0);
      hs_data.delete();
      hs_last.delete();
      hs_csum.delete();
      hs_cyc.delete();
      first_deq   = -1;
      first_valid = -1;
      deq_count   = 0;
   endtask

   task automatic run_drain(input int rdy_pct, input int gate_mode, input int budget);
      int   n = 0;
      logic g = 1'b0;
      while ((fq.size() > 0 || exp_q.size() > 0 || beat_idx == PKT_LEN) && n < budget) begin
         if (gate_mode == 1)
            g = ~g;
         else if (gate_mode == 2)
            g = ($urandom_range(99) < 30);
         else
            g = 1'b0;
         apply_stimulus(1'b0, ($urandom_range(99) < rdy_pct), g);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, budget);
      end
   endtask

   initial begin
      int          reset_end;
      int          n_exp;
      int          k;
      int          nd;
      logic [15:0] exp_vals[$];
      logic        exp_lasts[$];
      logic [15:0] pushed[$];
      logic [15:0] v;

      @(negedge clk);

      // Reset with the FIFO already holding data
      for (int i = 0; i < 4; i++) fq.push_back(16'h0100 + 16'(i));
      do_reset(3);
      reset_end = cycle;
      run_drain(100, 0, 50);
      check_output("first_deq_after_reset", first_deq - reset_end, 0);
      check_output("first_valid_latency", first_valid - first_deq, 2);

      // Full-rate stream of 1..16
      do_reset(2);
      for (int i = 1; i <= 16; i++) fq.push_back(16'(i));
      run_drain(100, 0, 100);
      exp_vals.delete();
      exp_lasts.delete();
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 8; j++) begin
            exp_vals.push_back(16'(p * 8 + j + 1));
            exp_lasts.push_back(!CSUM_ON && j == 7);
         end
         if (CSUM_ON) begin
            exp_vals.push_back((p == 0) ? 16'd36 : 16'd100);
            exp_lasts.push_back(1'b1);
         end
      end
      n_exp = exp_vals.size();
      check_output("fullrate_beats", hs_data.size(), n_exp);
      for (int i = 0; i < n_exp && i < hs_data.size(); i++) begin
         check_output("fullrate_data", {16'b0, hs_data[i]}, {16'b0, exp_vals[i]});
         check_output("fullrate_last", {31'b0, hs_last[i]}, {31'b0, exp_lasts[i]});
      end
      if (hs_cyc.size() > 0)
         check_output("fullrate_span", hs_cyc[hs_cyc.size() - 1] - hs_cyc[0], n_exp - 1);
      check_output("fullrate_pkt_cnt", {16'b0, pkt_cnt}, 32'd2);

      // Backpressure with five words waiting
      do_reset(2);
      for (int i = 0; i < 5; i++) fq.push_back(16'h0300 + 16'(i));
      repeat (10) apply_stimulus(1'b0, 1'b0, 1'b0);
      check_output("bp_pop_count", deq_count, 2);
      check_output("bp_deq_low", {31'b0, last_d}, 32'h0);
      run_drain(100, 0, 50);
      check_output("bp_beats", hs_data.size(), 5);
      for (int i = 0; i < 5 && i < hs_data.size(); i++)
         check_output("bp_order", {16'b0, hs_data[i]}, 32'h0300 + i);

      // FIFO empty flag toggling every cycle
      do_reset(2);
      pushed.delete();
      for (int i = 0; i < 20; i++) begin
         v = 16'h4000 + 16'(i * 7);
         fq.push_back(v);
         pushed.push_back(v);
      end
      run_drain(80, 1, 300);
      k = 0;
      for (int i = 0; i < hs_data.size(); i++) begin
         if (!hs_csum[i]) begin
            if (k < pushed.size())
               check_output("intermittent_order", {16'b0, hs_data[i]}, {16'b0, pushed[k]});
            k++;
         end
      end
      check_output("intermittent_count", k, 20);

      // Checksum wrap packet
      do_reset(2);
      fq.push_back(16'hFFFF);
      for (int i = 1; i <= 7; i++) fq.push_back(16'(i));
      run_drain(100, 0, 50);
      if (CSUM_ON) begin
         check_output("csum_beats", hs_data.size(), 9);
         if (hs_data.size() >= 9) begin
            check_output("csum_value", {16'b0, hs_data[8]}, 32'h001B);
            check_output("csum_last", {31'b0, hs_last[8]}, 32'h1);
            check_output("csum_word7_data", {16'b0, hs_data[7]}, 32'h7);
            check_output("csum_word7_last", {31'b0, hs_last[7]}, 32'h0);
         end
      end else begin
         check_output("pkt_beats", hs_data.size(), 8);
         if (hs_data.size() >= 8) begin
            check_output("pkt_word7_data", {16'b0, hs_data[7]}, 32'h7);
            check_output("pkt_word7_last", {31'b0, hs_last[7]}, 32'h1);
            check_output("pkt_word6_last", {31'b0, hs_last[6]}, 32'h0);
         end
      end

      // Reset in the middle of a packet
      do_reset(2);
      for (int i = 0; i < 8; i++) fq.push_back(16'h00A0 + 16'(i));
      nd = 0;
      while (hs_data.size() < 3 && nd < 20) begin
         apply_stimulus(1'b0, 1'b1, 1'b0);
         nd++;
      end
      check_output("midpkt_pre_beats", hs_data.size(), 3);
      fq.delete();
      do_reset(2);
      for (int i = 0; i < 8; i++) fq.push_back(16'h00B0 + 16'(i));
      run_drain(100, 0, 50);
      check_output("midpkt_pkt_cnt", {16'b0, pkt_cnt}, 32'd1);
      n_exp = CSUM_ON ? 9 : 8;
      check_output("midpkt_beats", hs_data.size(), n_exp);
      if (hs_data.size() >= n_exp) begin
         check_output("midpkt_last_data", {16'b0, hs_data[n_exp - 1]}, CSUM_ON ? 32'h059C : 32'h00B7);
         check_output("midpkt_last_flag", {31'b0, hs_last[n_exp - 1]}, 32'h1);
      end

      // Random traffic, ready and empty-flag gaps, with one reset midway
      do_reset(2);
      for (int i = 0; i < 400; i++) begin
         if (i == 200)
            do_reset(2);
         if ($urandom_range(99) < 40)
            fq.push_back(16'($urandom));
         apply_stimulus(1'b0, ($urandom_range(99) < 70), ($urandom_range(99) < 25));
      end
      run_drain(70, 2, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Downstream drain stage for the team's synchronous FIFO queue (`enq`/`deq` interface, registered `deq_data`, `full`/`empty` flags). It pops words from the FIFO and re-presents them on a valid/ready stream through a 2-entry output buffer. It frames the stream into fixed-length packets with an end-of-packet marker and keeps a running count of completed packets. It sits between the FIFO and any stream consumer (serializer, bus master).

## Interface
- `WIDTH`, 16: data word width; must match the FIFO `WIDTH`.
- `PKT_LEN`, 8: data words per packet, ≥ 2.
- `clk`  input  1  clock; all logic is rising-edge.
- `reset`  input  1  asynchronous, active-high.
- `fifo_deq`  output  1  pop request to the FIFO `deq` pin.
- `fifo_empty`  input  1  FIFO `empty` flag.
- `fifo_deq_data`  input  WIDTH  FIFO `deq_data`; valid the cycle after an accepted pop.
- `out_valid`  output  1  stream word valid.
- `out_ready`  input  1  consumer accepts the word.
- `out_data`  output  WIDTH  stream word.
- `out_last`  output  1  final word of the packet.
- `pkt_cnt`  output  16  completed-packet counter; wraps modulo 2^16.

## Operation
- **Buffer occupancy.** `occ` ranges 0..2. `inflight` is 1 when a pop was issued in the previous cycle.
- **Pop condition.** `pop_out` = `out_valid & out_ready & (state == DATA)`.
  - `fifo_deq` = `!reset & !fifo_empty & (occ + inflight - pop_out < 2)`.
  - `fifo_deq` is combinational; `fifo_deq_data` is sampled only when `inflight` = 1.
- **Buffer.** The 2-entry buffer is FIFO-ordered. The head drives `out_data` in DATA state. Capture and pop in the same cycle are both honoured.
- **Word counter.** `wcnt` ranges 0..PKT_LEN-1 and increments on each `pop_out`.
- **States.**
  - DATA: `out_valid` = (`occ` > 0).
  - CSUM: exists only with the macro (see Configuration).
- **`out_last`.** Without the macro, `out_last` = `out_valid & (wcnt == PKT_LEN-1)`. A handshake on that word clears `wcnt` to 0 and increments `pkt_cnt`.
- **Stream protocol.** Once `out_valid` is asserted, `out_data` and `out_last` hold until `out_ready`. `out_valid` never drops without a handshake.
- **Stale FIFO data.** `fifo_deq_data` is ignored whenever `inflight` = 0. The FIFO holds its last value, which must not be re-captured.
- **Reset.**
  - Registers cleared: `occ`, `inflight`, `wcnt`, `pkt_cnt`, state (DATA) and checksum accumulator.
  - Outputs during reset: `out_valid` = 0, `out_last` = 0, `out_data` = 0, `fifo_deq` = 0, `pkt_cnt` = 0.
  - Reset mid-packet discards the partial packet and any in-flight word. The next packet starts at `wcnt` = 0.

## Timing
- **Latency.** `fifo_deq` is high in cycle t. Data is captured at the end of t+1, and `out_valid` is high in cycle t+2.
- **Throughput.** Sustained 1 word/cycle with `out_ready` held high and the FIFO non-empty.
- **Backpressure.**
  - With `out_ready` low, at most 2 words are buffered.
  - `fifo_deq` drops once `occ + inflight` = 2.
  - The buffer never overflows.
- **FIFO drains.** `fifo_empty` high ⇒ no pop. The buffer drains normally, and `out_valid` falls after the last buffered word is accepted.
- **`pkt_cnt`.** Updates on the clock edge of the last-word handshake; it wraps 0xFFFF → 0x0000.

## Configuration
- Macro: `FIFO_PKT_READER_CHECKSUM_EN`.
- **Defined:**
  - An accumulator sums every data word handshaked in the packet, modulo 2^WIDTH.
  - The handshake of data word PKT_LEN-1 moves the FSM to CSUM, and that word has `out_last` = 0.
  - In CSUM, `out_valid` = 1, `out_data` = checksum (including the final word) and `out_last` = 1. Buffer pops are blocked; FIFO pops continue only up to buffer credit.
  - A handshake in CSUM returns the FSM to DATA, clears the accumulator and `wcnt`, and increments `pkt_cnt`.
  - Packets are PKT_LEN+1 beats.
- **Undefined:** no CSUM state and no accumulator. Packets are PKT_LEN beats, with `out_last` on data word PKT_LEN-1.

## Test plan
- **Reset values.** Assert reset with the FIFO non-empty, then release it. Expect `fifo_deq` = 0 during reset, all outputs 0, and the first `out_valid` exactly 2 cycles after the first `fifo_deq`.
- **Full-rate stream.** Enqueue 1..16 with `out_ready`=1 and `PKT_LEN`=8. Expect 16 consecutive beats 1..16, `out_last` on values 8 and 16, and `pkt_cnt` = 2.
- **Backpressure.** Set `out_ready`=0 for 10 cycles with the FIFO holding 5 words. Expect exactly 2 pops, then `fifo_deq` = 0. On release, expect words in order with no loss or duplication.
- **Intermittent FIFO.** Alternate `fifo_empty` every cycle. Expect no capture of stale `fifo_deq_data` and the output sequence to equal the enqueue sequence.
- **Checksum (macro on).** Send words 0xFFFF, 1, 2, 3, 4, 5, 6, 7. Expect beat 9 to be 0x001B with `out_last`=1, and beat 8 (value 7) to have `out_last`=0.
- **Reset mid-packet.** Reset after 3 beats, then send 8 new words. Expect `out_last` on the 8th new word, `pkt_cnt` = 1, and the checksum (macro on) covering only the new words.
